// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for a word-wide data memory
module mem_access_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_req,
    output logic                  o_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_we,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_rvalid,
    output logic                  o_err,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_we,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [1:0]  addr_lo;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [15:0] wdata_lo;
    logic        err_q;

    logic                  accept;
    logic                  req_err;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] merged;

    assign accept  = i_req && (state == S_IDLE);
    assign req_err = (i_size == 2'b11) ||
                     (i_size == 2'b01 && i_addr[0]) ||
                     (i_size == 2'b10 && i_addr[1:0] != 2'b00);

    assign o_ready  = (state == S_IDLE);
    assign o_mem_we = (state == S_WRITE);
    assign o_rvalid = (state == S_DONE);
    assign o_err    = (state == S_DONE) && err_q;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (i_req) begin
                    if (req_err)                 next_state = S_DONE;
                    else if (!i_we)              next_state = S_LOAD;
                    else if (i_size == 2'b10)    next_state = S_WRITE;
                    else                         next_state = S_RMW;
                end
            end
            S_LOAD:  next_state = S_DONE;
            S_RMW:   next_state = S_WRITE;
            S_WRITE: next_state = S_DONE;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Lane extraction for loads and lane replacement for sub-word stores
    always_comb begin
        byte_lane = i_mem_rdata[{addr_lo, 3'b000} +: 8];
        half_lane = i_mem_rdata[{addr_lo[1], 4'b0000} +: 16];
        load_val  = i_mem_rdata;
        merged    = i_mem_rdata;
        case (size_q)
            2'b00: begin
                load_val = unsigned_q ? {{(DATA_WIDTH-8){1'b0}}, byte_lane}
                                      : {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
                merged[{addr_lo, 3'b000} +: 8] = wdata_lo[7:0];
            end
            2'b01: begin
                load_val = unsigned_q ? {{(DATA_WIDTH-16){1'b0}}, half_lane}
                                      : {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
                merged[{addr_lo[1], 4'b0000} +: 16] = wdata_lo;
            end
            default: begin
                load_val = i_mem_rdata;
                merged   = i_mem_rdata;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            addr_lo     <= '0;
            size_q      <= '0;
            unsigned_q  <= 1'b0;
            wdata_lo    <= '0;
            err_q       <= 1'b0;
            o_rdata     <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            if (accept) begin
                addr_lo    <= i_addr[1:0];
                size_q     <= i_size;
                unsigned_q <= i_unsigned;
                wdata_lo   <= i_wdata[15:0];
                err_q      <= req_err;
                o_mem_addr <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                if (i_we && i_size == 2'b10 && !req_err) begin
                    o_mem_wdata <= i_wdata;
                end
            end
            if (state == S_LOAD) begin
                o_rdata <= load_val;
            end
            if (state == S_RMW) begin
                o_mem_wdata <= merged;
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store initiator that drives the word-wide data memory (asynchronous read, synchronous full-word write, byte addressed) on behalf of the core's load/store stage. Accepts one request at a time over a req/ready handshake. Performs byte, halfword and word accesses with sign or zero extension on loads. Sub-word stores use a read-modify-write, because the memory only writes whole words. Misaligned or reserved-size requests are rejected with an error response and never touch memory.

Parameters:
DATA_WIDTH, 32, data path width; only 32 is supported.
ADDR_WIDTH, 32, byte address width.

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_req  in  1  request valid
o_ready  out  1  unit idle and able to accept a request
i_addr  in  ADDR_WIDTH  byte address
i_we  in  1  1 = store, 0 = load
i_size  in  2  00 byte, 01 half, 10 word, 11 reserved
i_unsigned  in  1  loads only: 1 = zero extend, 0 = sign extend
i_wdata  in  DATA_WIDTH  store data; the low byte/half is used for sub-word stores
o_rvalid  out  1  one-cycle completion pulse (loads and stores)
o_err  out  1  valid with o_rvalid: misaligned or reserved size
o_rdata  out  DATA_WIDTH  load result; held until the next load completes
o_mem_addr  out  ADDR_WIDTH  word-aligned memory address
o_mem_we  out  1  memory write enable
o_mem_wdata  out  DATA_WIDTH  memory write data
i_mem_rdata  in  DATA_WIDTH  memory read data, combinational from o_mem_addr

Behaviour:
- Reset is asynchronous and active-low.
  - While i_reset=0: state=IDLE, o_ready=1.
  - o_rvalid, o_err and o_mem_we are 0.
  - o_rdata, o_mem_addr and o_mem_wdata are 0.
- Handshake:
  - A request is accepted on a rising edge where i_req=1 and o_ready=1.
  - At acceptance, addr, we, size, unsigned and wdata are latched.
  - o_ready=1 only in IDLE.
  - i_req held high while busy is ignored until the unit returns to IDLE.
- o_mem_addr is a register: {addr[ADDR_WIDTH-1:2], 2'b00}, loaded at acceptance and held otherwise.
- o_mem_we=1 only in state WRITE; it is decoded from state with no registered delay.
- Lanes are little-endian.
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
- Error conditions: half with addr[0]=1; word with addr[1:0]!=0; size=11.
- States:
  - IDLE:
    - Accept with error -> DONE, err=1.
    - Accept load -> LOAD.
    - Accept word store -> WRITE, o_mem_wdata=wdata.
    - Accept sub-word store -> RMW.
  - LOAD: capture i_mem_rdata, extract the lane, extend to 32 bits, register it into o_rdata at the edge -> DONE.
  - RMW: capture i_mem_rdata, replace the addressed lane with the low byte/half of wdata, register the result into o_mem_wdata -> WRITE.
  - WRITE: o_mem_we=1 for exactly one cycle -> DONE.
  - DONE: o_rvalid=1 for one cycle, o_err=latched err -> IDLE.
- o_err=0 whenever o_rvalid=0.
- o_rdata is unchanged by stores and by error responses.
- Latency from the acceptance edge to the o_rvalid cycle:
  - error: 1 cycle
  - load or word store: 2 cycles
  - sub-word store: 3 cycles
- Throughput is one request per latency+1 cycles.
- An error response never asserts o_mem_we.
- Reset asserted mid-operation abandons the request with no response pulse.
  - If reset is asserted during WRITE, o_mem_we drops immediately and memory is not modified.
- Extension rules:
  - Signed byte: bits [31:8] = bit 7 of the byte.
  - Signed half: bits [31:16] = bit 15 of the half.
  - Unsigned: upper bits are 0.
  - i_unsigned is ignored for word accesses.

Test Plan:
1. Preload 0x8899AABB at 0x10; signed byte load at 0x11 -> o_rvalid 2 cycles after accept, o_rdata=0xFFFFFFAA, o_err=0. Repeat unsigned -> 0x000000AA.
2. Signed half load at 0x12 -> 0xFFFF8899. Unsigned half load at 0x10 -> 0x0000AABB. Word load at 0x10 -> 0x8899AABB. o_mem_addr=0x10 in every case.
3. Byte store at 0x13 with i_wdata=0x12345655 -> RMW then exactly one o_mem_we cycle with o_mem_wdata=0x5599AABB; o_rvalid 3 cycles after accept. A following word load at 0x10 returns 0x5599AABB, and o_rdata holds its previous value until that load completes.
4. Word load at 0x22, half load at 0x13, and a request with size=11 -> each gives o_rvalid=o_err=1 one cycle after accept, o_mem_we never asserted, memory and o_rdata unchanged.
5. Hold i_req=1 with two queued requests -> the second is accepted only on the first edge after DONE (o_ready=1); no request is lost or duplicated.
6. Assert i_reset low during WRITE of a byte store at 0x10 -> o_mem_we falls immediately, memory word unchanged, no o_rvalid pulse, o_ready=1 after release, and the next load completes normally.
